// File: rtl/data_mem_if.sv
// Load/store port bundle between the core and data_mem. The shared data bus is a
// separate inout port on data_mem so the tristate stays a plain module-level net.
interface data_mem_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 32
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0] dmem_addr;
    logic            dmem_wen;
    logic [2:0]      dmem_width;
    logic            fault_clr;
    logic            fault;
    logic [AW-1:0]   fault_addr;

    modport master (
        output dmem_addr, dmem_wen, dmem_width, fault_clr,
        input  fault, fault_addr
    );

    modport slave (
        input  dmem_addr, dmem_wen, dmem_width, fault_clr,
        output fault, fault_addr
    );
endinterface

// File: rtl/data_mem.sv
// Byte-addressed data memory with combinational little-endian loads and byte/half/word stores.
// Optional feature macro DMEM_ALIGN_CHECK_EN: reject misaligned/illegal stores into a fault reg.
module data_mem #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_if.slave       bus,
    inout  wire [XLEN-1:0]  dmem_data
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] a;
    logic [AW-1:0] idx [4];
    logic [3:0]    be;
    logic          legal;
    logic          misaligned;
    logic          wr_en;
    logic [31:0]   load_word;

    assign a = bus.dmem_addr[AW-1:0];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = a + AW'(k);
        end
        legal = 1'b1;
        be    = 4'b0000;
        case (bus.dmem_width)
            3'b000:  be = 4'b0001;
            3'b001:  be = 4'b0011;
            3'b010:  be = 4'b1111;
            default: legal = 1'b0;
        endcase
        misaligned = ((bus.dmem_width == 3'b010) && (a[1:0] != 2'b00)) ||
                     ((bus.dmem_width == 3'b001) && a[0]);
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic fault_set;
    logic fault_q;
    logic [AW-1:0] fault_addr_q;

    assign wr_en     = bus.dmem_wen & legal & ~misaligned;
    assign fault_set = bus.dmem_wen & (~legal | misaligned);

    // A new fault wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else if (fault_set) begin
            fault_q      <= 1'b1;
            fault_addr_q <= a;
        end else if (bus.fault_clr) begin
            fault_q      <= 1'b0;
        end
    end

    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;

    logic unused_bits;
    assign unused_bits = ^{bus.dmem_addr, dmem_data};
`else
    // Misaligned accesses simply wrap byte-by-byte through idx[].
    assign wr_en          = bus.dmem_wen & legal;
    assign bus.fault      = 1'b0;
    assign bus.fault_addr = '0;

    logic unused_bits;
    assign unused_bits = ^{bus.dmem_addr, dmem_data, bus.fault_clr, misaligned};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem_q[idx[k]] <= dmem_data[8*k +: 8];
                end
            end
        end
    end

    assign load_word = {mem_q[idx[3]], mem_q[idx[2]], mem_q[idx[1]], mem_q[idx[0]]};
    assign dmem_data = bus.dmem_wen ? {XLEN{1'bz}} : XLEN'(load_word);
endmodule
